// File: rtl/mux8_32.sv
//==============================================================================
// Module      : mux8_32
// Description : Byte-to-word packer for the receive side of the byte link.
//               Collects LANES consecutive valid bytes on clk_4f and presents
//               them as one word with a single-cycle valid_out strobe. The
//               first byte of a word lands in the most significant lane.
//               Words broken off early are dropped and counted.
//
// Ports       : clk_4f    - byte-rate clock, all logic on its rising edge
//               reset     - asynchronous, active-high; clears all state
//               data_in   - input byte, sampled when valid_in = 1
//               valid_in  - byte qualifier, low between/around words
//               data_out  - last completed word, held until the next one
//               valid_out - 1-cycle pulse: new word on data_out
//               frag_err  - 1-cycle pulse: partial word discarded
//               frag_cnt  - saturating count of discarded partial words
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux8_32 #(
  parameter int BYTE_W = 8,   // width of one input byte
  parameter int LANES  = 4,   // bytes per word (2 or more)
  parameter int ERR_W  = 8    // width of the fragment-error counter
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic [BYTE_W-1:0]         data_in,
  input  logic                      valid_in,
  output logic [BYTE_W*LANES-1:0]   data_out,
  output logic                      valid_out,
  output logic                      frag_err,
  output logic [ERR_W-1:0]          frag_cnt
);

  localparam int                 c_IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int                 c_SHIFT_W = BYTE_W * (LANES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ZERO = '0;
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(LANES - 1);
  localparam logic [ERR_W-1:0]   c_CNT_MAX  = '1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t                   r_state;
  logic [c_IDX_W-1:0]       r_idx;
  logic [c_SHIFT_W-1:0]     r_shift;    // lanes 0..LANES-2, lane 0 in the MSBs
  logic [BYTE_W*LANES-1:0]  r_data;
  logic                     r_valid;
  logic                     r_frag;
  logic [ERR_W-1:0]         r_cnt;

  logic [c_SHIFT_W-1:0]     w_shift_nxt;
  logic                     w_last;

  // The final byte of a word is never stored: it goes straight into the
  // output word together with the held lanes.
  assign w_last = (r_idx == c_IDX_LAST);

  // Drop the incoming byte into the lane selected by r_idx. In IDLE r_idx is
  // always zero, so the same path loads lane 0 of a fresh word.
  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < LANES - 1; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_shift_nxt[(LANES - 2 - i) * BYTE_W +: BYTE_W] = data_in;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= c_IDX_ZERO;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_frag  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // Both strobes are single-cycle by construction.
      r_valid <= 1'b0;
      r_frag  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_shift <= w_shift_nxt;
            r_idx   <= c_IDX_ONE;
            r_state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (valid_in) begin
            if (w_last) begin
              // Word complete; stay in COLLECT so a following byte starts
              // the next word with no bubble.
              r_data  <= {r_shift, data_in};
              r_valid <= 1'b1;
              r_idx   <= c_IDX_ZERO;
            end else begin
              r_shift <= w_shift_nxt;
              r_idx   <= r_idx + c_IDX_ONE;
            end
          end else begin
            r_idx   <= c_IDX_ZERO;
            r_state <= ST_IDLE;
            // idx==0 is a clean word boundary: nothing was lost.
            if (r_idx != c_IDX_ZERO) begin
              r_frag <= 1'b1;
              if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + ERR_W'(1);
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_idx   <= c_IDX_ZERO;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign frag_err  = r_frag;
  assign frag_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mux8_32.sv
//==============================================================================
// Module      : tb_mux8_32
// Description : Scoreboard bench for mux8_32. The stimulus process pushes the
//               expected event (word or fragment, with the cycle it must
//               appear in) into a queue; a monitor on the falling edge pops
//               and compares whenever valid_out or frag_err is high.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux8_32;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frag_err;
  logic [7:0]  frag_cnt;

  typedef struct {
    logic        is_word;
    logic [31:0] word;
    logic [7:0]  cnt;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  logic [7:0]  exp_cnt = 8'h00;

  mux8_32 #(.BYTE_W(8), .LANES(4), .ERR_W(8)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .frag_err  (frag_err),
    .frag_cnt  (frag_cnt)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  always @(posedge clk_4f) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected event per output strobe.
  always @(negedge clk_4f) begin
    if (!reset) begin
      if (valid_out && frag_err) begin
        checks++;
        errors++;
        $display("FAIL strobes_overlap: valid_out=1 frag_err=1 at cycle %0d", cyc);
      end
      if (valid_out || frag_err) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: valid_out=%b frag_err=%b data_out=%h frag_cnt=%h cycle %0d, none expected",
                   valid_out, frag_err, data_out, frag_cnt, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (valid_out !== e.is_word || frag_err !== !e.is_word ||
              (e.is_word && data_out !== e.word) || frag_cnt !== e.cnt || cyc != e.cyc) begin
            errors++;
            $display("FAIL event: got word=%b data=%h cnt=%h cyc=%0d expected word=%b data=%h cnt=%h cyc=%0d",
                     valid_out, data_out, frag_cnt, cyc, e.is_word, e.word, e.cnt, e.cyc);
          end
        end
      end
    end
  end

  // Drive one cycle of input, then step past the sampling edge.
  task automatic put(input logic v, input logic [7:0] b);
    valid_in = v;
    data_in  = b;
    @(posedge clk_4f);
    #1;
  endtask

  // Last byte of a word: expect the word to be strobed after this edge.
  task automatic put_last(input logic [7:0] b, input logic [31:0] w);
    ev_t e;
    e.is_word = 1'b1; e.word = w; e.cnt = exp_cnt; e.cyc = cyc + 1;
    q.push_back(e);
    put(1'b1, b);
  endtask

  // Gap after a partial word: expect a fragment strobe after this edge.
  task automatic put_gap_frag();
    ev_t e;
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
    e.is_word = 1'b0; e.word = 32'h0; e.cnt = exp_cnt; e.cyc = cyc + 1;
    q.push_back(e);
    put(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    put(1'b1, w[31:24]);
    put(1'b1, w[23:16]);
    put(1'b1, w[15:8]);
    put_last(w[7:0], w);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #12;
    chk("reset_data_out",  data_out,  32'h0);
    chk("reset_valid_out", {31'h0, valid_out}, 32'h0);
    chk("reset_frag_err",  {31'h0, frag_err},  32'h0);
    chk("reset_frag_cnt",  {24'h0, frag_cnt},  32'h0);
    #5 reset = 1'b0;
    @(posedge clk_4f); #1;
    put(1'b0, 8'h00);

    // Single word, then a clean gap.
    put(1'b1, 8'hAA); put(1'b1, 8'hBB); put(1'b1, 8'hCC);
    put_last(8'hDD, 32'hAABBCCDD);
    put(1'b0, 8'h00);
    put(1'b0, 8'h00);
    chk("single_hold", data_out, 32'hAABBCCDD);
    chk("single_no_frag_cnt", {24'h0, frag_cnt}, 32'h0);

    // Streaming: three back-to-back words, no bubbles.
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    put(1'b0, 8'h00);
    put(1'b0, 8'h00);

    // Fragment followed by a good word.
    put(1'b1, 8'h11); put(1'b1, 8'h22);
    put_gap_frag();
    put(1'b0, 8'h00);
    chk("frag_cnt_one", {24'h0, frag_cnt}, 32'h1);
    put(1'b1, 8'h33); put(1'b1, 8'h44); put(1'b1, 8'h55);
    chk("frag_data_hold", data_out, 32'h090A0B0C);
    put_last(8'h66, 32'h33445566);
    put(1'b0, 8'h00);
    put(1'b0, 8'h00);

    // Asynchronous reset in the middle of a word.
    put(1'b1, 8'h77); put(1'b1, 8'h88);
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("midreset_data_out",  data_out, 32'h0);
    chk("midreset_valid_out", {31'h0, valid_out}, 32'h0);
    chk("midreset_frag_err",  {31'h0, frag_err},  32'h0);
    chk("midreset_frag_cnt",  {24'h0, frag_cnt},  32'h0);
    chk("midreset_queue_empty", q.size(), 32'h0);
    exp_cnt = 8'h00;
    @(posedge clk_4f); @(posedge clk_4f); #3;
    reset = 1'b0;
    @(posedge clk_4f); #1;
    for (int i = 0; i < 5; i++) put(1'b0, 8'h00);
    chk("post_reset_frag_cnt", {24'h0, frag_cnt}, 32'h0);

    // Saturation: 300 two-byte fragments.
    for (int i = 0; i < 300; i++) begin
      put(1'b1, 8'(i));
      put(1'b1, 8'(i + 1));
      put_gap_frag();
    end
    put(1'b0, 8'h00);
    chk("sat_frag_cnt", {24'h0, frag_cnt}, 32'hFF);
    send_word(32'hDEADBEEF);
    put(1'b0, 8'h00);
    chk("sat_after_word", {24'h0, frag_cnt}, 32'hFF);

    // Loopback: serialise random words MSB-first with gaps only on word
    // boundaries; every word must come back intact and in order.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] w;
      int gap;
      w   = $urandom;
      gap = $urandom_range(0, 2);
      send_word(w);
      for (int g = 0; g < gap; g++) put(1'b0, 8'h00);
    end
    for (int i = 0; i < 4; i++) put(1'b0, 8'h00);
    chk("loop_frag_cnt", {24'h0, frag_cnt}, 32'hFF);
    chk("queue_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
